// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter: round-robin arbiter sharing one byte-wide uart_tx
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_strobe,
  input  logic               tx_ready,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;

  // Search begins just after the last released owner, so the previous owner
  // has lowest priority next round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (tx_ready && win_found) begin
          state_d = SEND;
          owner_d = win_idx;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          data_d  = req_data[{win_idx, 3'b000} +: 8];
          last_d  = req_last[win_idx];
          cnt_d   = 8'd1;
        end
      end
      SEND: begin
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_ready) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_ready) begin
          if (last_q || (cnt_q == 8'(MAX_LEN)) || !req[owner_q]) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = owner_q;
          end else begin
            state_d = SEND;
            data_d  = req_data[{owner_q, 3'b000} +: 8];
            last_d  = req_last[owner_q];
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe and ack come from SEND alone, keeping both single-cycle and owner-only.
  assign tx_strobe = (state_q == SEND);
  assign ack       = tx_strobe ? grant_q : '0;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign tx_data   = data_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one byte-wide uart_tx (2..8).
REQ-002 Parameter MAX_LEN, default 16: maximum bytes per grant before forced release (1..255).
REQ-003 mclk  in  1  system clock; the block uses only this one clock and every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of mclk.
REQ-005 req  in  N_REQ  per-requester request; held high while a byte is presented.
REQ-006 req_data  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
REQ-007 req_last  in  N_REQ  marks the presented byte as the last byte of the message.
REQ-008 ack  out  N_REQ  one-cycle pulse: requester's current byte consumed; requester presents its next byte from the following cycle.
REQ-009 grant  out  N_REQ  one-hot owner of the transmitter; all zero when idle.
REQ-010 tx_data  out  8  byte to uart_tx data port.
REQ-011 tx_strobe  out  1  one-cycle pulse to uart_tx data_strobe.
REQ-012 tx_ready  in  1  uart_tx ready (high = idle).
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, SEND, WAIT_LO, WAIT_HI.
REQ-015 IDLE: if tx_ready=1 and any req bit is set, select a winner round-robin, register grant, latch tx_data from req_data[winner], latch req_last[winner] into last_q, set byte count to 1, go to SEND; otherwise stay in IDLE.
REQ-016 Round-robin: search starts at index ptr+1 modulo N_REQ, where ptr is the index of the last released owner.
REQ-017 SEND lasts exactly one cycle, with tx_strobe=1 and ack[owner]=1; next state is WAIT_LO.
REQ-018 tx_strobe and ack SHALL be decoded from state SEND only, so each is exactly one cycle wide and ack is never asserted to a non-owner.
REQ-019 Latency: with req sampled in IDLE at edge N, SEND (tx_strobe) occupies the cycle after edge N.
REQ-020 WAIT_LO: stay until tx_ready=0, then go to WAIT_HI; there is no timeout.
REQ-021 WAIT_HI: stay until tx_ready=1, then release if any of the following holds: last_q=1, byte count = MAX_LEN, or req[owner]=0.
REQ-022 WAIT_HI, no release: latch req_data[owner] and req_last[owner], increment the byte count, go to SEND; grant is unchanged.
REQ-023 Release: set grant to 0, set ptr to the owner index, go to IDLE; re-arbitration happens no earlier than the next cycle.
REQ-024 tx_data SHALL hold its value from one latch to the next; it changes only on edges that enter SEND.
REQ-025 Other requesters' req bits are ignored while a grant is held; no preemption.
REQ-026 If tx_ready is low in IDLE, no grant is issued regardless of req.
REQ-027 The byte counter is 8 bits; MAX_LEN release occurs before any wrap.
REQ-028 A single requester may win again immediately after release if it is the only one requesting.

Reset
REQ-029 On reset: state=IDLE, grant=0, ack=0, tx_strobe=0, tx_data=8'h00, busy=0, byte count=0, last_q=0, ptr=N_REQ-1 (so requester 0 has first priority).
REQ-030 A reset in any state takes effect at that edge; an in-flight message is abandoned without an ack, and no further strobe is issued.

Verification
REQ-031 Single requester: req[0]=1 with bytes 8'h31, 8'h32, 8'h33 (last=1 on the third), using a uart_tx model (ready low 10 cycles after each strobe) -> three strobes in order, three ack[0] pulses, grant=4'b0001 throughout, then IDLE.
REQ-032 Round-robin: req=4'b1111 continuously, one-byte messages (last=1) -> grant order 0,1,2,3,0,1.
REQ-033 MAX_LEN=4, req[2] streaming with last=0 and req[1] also pending -> requester 2 released after 4 bytes, then requester 1 granted.
REQ-034 Abort: the owner drops req during WAIT_LO after byte 2 -> no third strobe, release when tx_ready returns high, ptr equals the owner index.
REQ-035 Reset asserted during WAIT_LO -> next cycle all outputs are at their reset values; with req[3]=1 and req[0]=1 after reset, requester 0 is granted first.
REQ-036 tx_ready held low with req=4'b0001 -> grant stays 0 and no strobe; when tx_ready rises at edge N, tx_strobe is high in the cycle after edge N.
